// File: rtl/dtw_scorer_if.sv
// Handshake and frame-memory bus between the DTW scorer and its controller.
// The master starts runs and supplies frame data; the slave is the scorer.
interface dtw_scorer_if #(
    parameter int LEN_W    = 6,
    parameter int FEATURES = 12,
    parameter int FEAT_W   = 8,
    parameter int SCORE_W  = 16
);
    logic                         start;
    logic [LEN_W-1:0]             len_a;
    logic [LEN_W-1:0]             len_b;
    logic [LEN_W-1:0]             rd_addr_a;
    logic [LEN_W-1:0]             rd_addr_b;
    logic [FEATURES*FEAT_W-1:0]   rd_data_a;
    logic [FEATURES*FEAT_W-1:0]   rd_data_b;
    logic [SCORE_W-1:0]           score;
    logic                         done;
    logic                         busy;
    logic                         err;

    modport master (
        output start, len_a, len_b, rd_data_a, rd_data_b,
        input  rd_addr_a, rd_addr_b, score, done, busy, err
    );

    modport slave (
        input  start, len_a, len_b, rd_data_a, rd_data_b,
        output rd_addr_a, rd_addr_b, score, done, busy, err
    );
endinterface

// File: rtl/dtw_scorer.sv
// Dynamic-time-warping scorer: saturating cumulative L1 distance between two
// frame sequences read from external 1-cycle-latency memories, with optional band.
module dtw_scorer #(
    parameter int MAX_FRAMES = 40,
    parameter int LEN_W      = 6,
    parameter int FEATURES   = 12,
    parameter int FEAT_W     = 8,
    parameter int SCORE_W    = 16,
    parameter int BAND       = 40
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    dtw_scorer_if.slave dtw_io
);
    localparam int D_W   = FEAT_W + $clog2(FEATURES);
    localparam int SUM_W = ((SCORE_W > D_W) ? SCORE_W : D_W) + 1;
    localparam logic [SCORE_W-1:0] INF = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_ROW_A, S_CELL_ADDR, S_CELL_CALC, S_FINISH
    } state_t;

    state_t                     state_q;
    logic [LEN_W-1:0]           len_a_q, len_b_q;
    logic [LEN_W-1:0]           addr_a_q, addr_b_q;
    logic [FEATURES*FEAT_W-1:0] a_frame_q;
    logic                       row_sel_q;
    logic [SCORE_W-1:0]         score_q;
    logic                       done_q, busy_q, err_q;
    logic [SCORE_W-1:0]         rows_q [2][MAX_FRAMES];

    logic [FEAT_W-1:0]          absdiff [FEATURES];
    logic [D_W-1:0]             local_d;
    logic [SCORE_W-1:0]         up_d, left_d, diag_d, min_d, cell_d;
    logic [SUM_W-1:0]           sum_d;
    logic [LEN_W-1:0]           j_m1, dist_d;
    logic                       len_bad;

    // The read addresses double as the row (i) and column (j) counters.
    for (genvar gi = 0; gi < FEATURES; gi++) begin : g_absdiff
        logic [FEAT_W-1:0] af, bf;
        logic [FEAT_W:0]   diff;
        assign af   = a_frame_q[gi*FEAT_W +: FEAT_W];
        assign bf   = dtw_io.rd_data_b[gi*FEAT_W +: FEAT_W];
        assign diff = {af[FEAT_W-1], af} - {bf[FEAT_W-1], bf};
        assign absdiff[gi] = diff[FEAT_W] ? FEAT_W'(-diff) : diff[FEAT_W-1:0];
    end

    always_comb begin
        local_d = '0;
        for (int f = 0; f < FEATURES; f++) begin
            local_d = local_d + D_W'(absdiff[f]);
        end
    end

    always_comb begin
        j_m1   = addr_b_q - LEN_W'(1);
        up_d   = INF;
        left_d = INF;
        diag_d = INF;
        if (addr_a_q != '0) begin
            up_d = rows_q[~row_sel_q][addr_b_q];
            if (addr_b_q != '0) diag_d = rows_q[~row_sel_q][j_m1];
        end
        if (addr_b_q != '0) left_d = rows_q[row_sel_q][j_m1];

        min_d = up_d;
        if (left_d < min_d) min_d = left_d;
        if (diag_d < min_d) min_d = diag_d;
        if (addr_a_q == '0 && addr_b_q == '0) min_d = '0;

        sum_d = SUM_W'(min_d) + SUM_W'(local_d);
        if (min_d == INF || sum_d >= SUM_W'(INF)) cell_d = INF;
        else                                        cell_d = sum_d[SCORE_W-1:0];

        dist_d = (addr_a_q >= addr_b_q) ? addr_a_q - addr_b_q : addr_b_q - addr_a_q;
        if (32'(dist_d) > BAND) cell_d = INF;
    end

    assign len_bad = (dtw_io.len_a == '0) || (dtw_io.len_b == '0) ||
                     (32'(dtw_io.len_a) > MAX_FRAMES) || (32'(dtw_io.len_b) > MAX_FRAMES);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            len_a_q   <= '0;
            len_b_q   <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            a_frame_q <= '0;
            row_sel_q <= 1'b0;
            score_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (dtw_io.start) begin
                    len_a_q <= dtw_io.len_a;
                    len_b_q <= dtw_io.len_b;
                    if (len_bad) begin
                        state_q <= S_FINISH;
                        score_q <= INF;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_ROW_A;
                        busy_q   <= 1'b1;
                        addr_a_q <= '0;
                    end
                end
                S_ROW_A: begin
                    addr_b_q <= '0;
                    state_q  <= S_CELL_ADDR;
                end
                S_CELL_ADDR: begin
                    if (addr_b_q == '0) a_frame_q <= dtw_io.rd_data_a;
                    state_q <= S_CELL_CALC;
                end
                S_CELL_CALC: begin
                    if (addr_b_q == len_b_q - LEN_W'(1)) begin
                        row_sel_q <= ~row_sel_q;
                        if (addr_a_q == len_a_q - LEN_W'(1)) begin
                            state_q <= S_FINISH;
                            score_q <= cell_d;
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            addr_a_q <= addr_a_q + LEN_W'(1);
                            state_q  <= S_ROW_A;
                        end
                    end else begin
                        addr_b_q <= addr_b_q + LEN_W'(1);
                        state_q  <= S_CELL_ADDR;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Row buffers need no reset: row 0 never reads the previous row.
    always_ff @(posedge clock_i) begin
        if (state_q == S_CELL_CALC) rows_q[row_sel_q][addr_b_q] <= cell_d;
    end

    assign dtw_io.rd_addr_a = addr_a_q;
    assign dtw_io.rd_addr_b = addr_b_q;
    assign dtw_io.score     = score_q;
    assign dtw_io.done      = done_q;
    assign dtw_io.busy      = busy_q;
    assign dtw_io.err       = err_q;
endmodule

// File: tb/tb_dtw_scorer.sv
// Self-checking bench for dtw_scorer: a full-matrix DTW reference model checks
// a wide unbanded scorer and a narrow (8-bit, band 2) scorer sharing frame memories.
module tb_dtw_scorer;
    localparam int LW = 6, NF = 12, FW = 8, MAXF = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dtw_scorer_if #(.LEN_W(LW), .FEATURES(NF), .FEAT_W(FW), .SCORE_W(16)) bus0 ();
    dtw_scorer_if #(.LEN_W(LW), .FEATURES(NF), .FEAT_W(FW), .SCORE_W(8))  bus1 ();

    dtw_scorer #(.MAX_FRAMES(MAXF), .LEN_W(LW), .FEATURES(NF), .FEAT_W(FW),
                 .SCORE_W(16), .BAND(40)) dut0 (.clock_i(clk), .reset_n_i(rst_n), .dtw_io(bus0));
    dtw_scorer #(.MAX_FRAMES(MAXF), .LEN_W(LW), .FEATURES(NF), .FEAT_W(FW),
                 .SCORE_W(8), .BAND(2))   dut1 (.clock_i(clk), .reset_n_i(rst_n), .dtw_io(bus1));

    logic signed [FW-1:0] fa [64][NF];
    logic signed [FW-1:0] fb [64][NF];

    logic          start_v = 1'b0;
    logic [LW-1:0] len_a_v = '0;
    logic [LW-1:0] len_b_v = '0;
    logic          sel = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            last_a [2];
    int            last_b [2];

    assign bus0.start = start_v & ~sel;
    assign bus1.start = start_v & sel;
    assign bus0.len_a = len_a_v;
    assign bus0.len_b = len_b_v;
    assign bus1.len_a = len_a_v;
    assign bus1.len_b = len_b_v;

    // Frame memories with exactly one cycle of read latency.
    always @(posedge clk) begin
        for (int f = 0; f < NF; f++) begin
            bus0.rd_data_a[f*FW +: FW] <= fa[bus0.rd_addr_a][f];
            bus0.rd_data_b[f*FW +: FW] <= fb[bus0.rd_addr_b][f];
            bus1.rd_data_a[f*FW +: FW] <= fa[bus1.rd_addr_a][f];
            bus1.rd_data_b[f*FW +: FW] <= fb[bus1.rd_addr_b][f];
        end
    end

    logic [15:0]   o_score;
    logic          o_done, o_busy, o_err;
    logic [LW-1:0] o_addr_a, o_addr_b;
    always_comb begin
        if (sel) begin
            o_score  = {8'h00, bus1.score};
            o_done   = bus1.done;
            o_busy   = bus1.busy;
            o_err    = bus1.err;
            o_addr_a = bus1.rd_addr_a;
            o_addr_b = bus1.rd_addr_b;
        end else begin
            o_score  = bus0.score;
            o_done   = bus0.done;
            o_busy   = bus0.busy;
            o_err    = bus0.err;
            o_addr_a = bus0.rd_addr_a;
            o_addr_b = bus0.rd_addr_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Whole cost matrix computed straight from the recurrence.
    task automatic model(input int la, input int lb, input int band, input int sw,
                         output int score, output bit err);
        int inf, d, m, v, x;
        int cost [MAXF][MAXF];
        inf   = (1 << sw) - 1;
        err   = (la < 1 || lb < 1 || la > MAXF || lb > MAXF);
        score = inf;
        if (!err) begin
            for (int i = 0; i < la; i++) begin
                for (int j = 0; j < lb; j++) begin
                    d = 0;
                    for (int f = 0; f < NF; f++) begin
                        x = int'(fa[i][f]) - int'(fb[j][f]);
                        d += (x < 0) ? -x : x;
                    end
                    if (i == 0 && j == 0) m = 0;
                    else begin
                        m = inf;
                        if (i > 0 && cost[i-1][j] < m) m = cost[i-1][j];
                        if (j > 0 && cost[i][j-1] < m) m = cost[i][j-1];
                        if (i > 0 && j > 0 && cost[i-1][j-1] < m) m = cost[i-1][j-1];
                    end
                    v = (m + d >= inf) ? inf : m + d;
                    if (i - j > band || j - i > band) v = inf;
                    cost[i][j] = v;
                end
            end
            score = cost[la-1][lb-1];
        end
    endtask

    task automatic fill(input int alo, input int ahi, input int blo, input int bhi);
        for (int i = 0; i < 64; i++) begin
            for (int f = 0; f < NF; f++) begin
                fa[i][f] = FW'(alo + int'($urandom_range(ahi - alo, 0)));
                fb[i][f] = FW'(blo + int'($urandom_range(bhi - blo, 0)));
            end
        end
    endtask

    task automatic run_case(input string tag, input int which, input int la, input int lb,
                            input int poke, input int known);
        int exp_score, exp_cycle, cyc, busy_bad, extra_done;
        bit exp_err, seen;
        logic [15:0] got_score;
        model(la, lb, (which != 0) ? 2 : 40, (which != 0) ? 8 : 16, exp_score, exp_err);
        exp_cycle = exp_err ? 1 : la * (1 + 2 * lb) + 1;
        @(negedge clk);
        sel     = (which != 0);
        len_a_v = LW'(la);
        len_b_v = LW'(lb);
        start_v = 1'b1;
        @(negedge clk);
        start_v  = 1'b0;
        cyc      = 1;
        seen     = 1'b0;
        busy_bad = 0;
        while (cyc < 5000) begin
            start_v = (cyc == poke);
            if (cyc == poke) begin
                len_a_v = LW'(1);
                len_b_v = LW'(1);
            end
            if (o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (o_busy !== 1'b1) busy_bad++;
            @(negedge clk);
            cyc++;
        end
        start_v   = 1'b0;
        got_score = o_score;
        $display("[TB] %s: la=%0d lb=%0d score=%0d err=%0d done_cycle=%0d", tag, la, lb,
                 got_score, o_err, cyc);
        check({tag, ".done_seen"}, 32'(seen), 1);
        check({tag, ".done_cycle"}, cyc, exp_cycle);
        check({tag, ".score"}, got_score, exp_score);
        check({tag, ".err"}, o_err, 32'(exp_err));
        check({tag, ".busy_at_done"}, o_busy, 0);
        check({tag, ".busy_before_done"}, busy_bad, 0);
        if (known >= 0) check({tag, ".known_score"}, got_score, known);
        if (exp_err) begin
            check({tag, ".addr_a_held"}, o_addr_a, last_a[which]);
            check({tag, ".addr_b_held"}, o_addr_b, last_b[which]);
        end else begin
            check({tag, ".addr_a_last"}, o_addr_a, la - 1);
            check({tag, ".addr_b_last"}, o_addr_b, lb - 1);
            last_a[which] = la - 1;
            last_b[which] = lb - 1;
        end
        extra_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_done !== 1'b0) extra_done++;
        end
        check({tag, ".single_done"}, extra_done, 0);
        check({tag, ".score_held"}, o_score, exp_score);
    endtask

    initial begin
        int dones;
        last_a = '{0, 0};
        last_b = '{0, 0};
        fill(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset.score", o_score, 0);
        check("reset.done", o_done, 0);
        check("reset.busy", o_busy, 0);
        check("reset.err", o_err, 0);
        check("reset.addr_a", o_addr_a, 0);
        check("reset.addr_b", o_addr_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(-128, 127, 0, 0);
        for (int i = 0; i < 64; i++) fb[i] = fa[i];
        run_case("identical", 0, 4, 4, 0, 0);

        fill(0, 0, 1, 1);
        run_case("offset", 0, 3, 3, 0, 36);

        fill(0, 0, 0, 0);
        run_case("band", 1, 2, 5, 0, 255);

        fill(0, 0, 127, 127);
        run_case("saturate", 1, 1, 1, 0, 255);

        run_case("len_b_zero", 0, 3, 0, 0, 65535);
        run_case("len_a_41", 0, 41, 3, 0, 65535);

        for (int k = 0; k < 6; k++) begin
            fill(-128, 127, -128, 127);
            run_case("rand_wide", 0, int'($urandom_range(8, 1)), int'($urandom_range(8, 1)), 0, -1);
        end
        for (int k = 0; k < 5; k++) begin
            fill(-3, 3, -3, 3);
            run_case("rand_band", 1, int'($urandom_range(6, 1)), int'($urandom_range(6, 1)), 0, -1);
        end

        fill(-2, 2, -2, 2);
        run_case("max_len", 0, 40, 3, 0, -1);

        fill(-128, 127, -128, 127);
        run_case("start_busy", 0, 5, 4, 7, -1);

        // Abort a run with reset and confirm nothing completes.
        fill(-128, 127, -128, 127);
        @(negedge clk);
        sel     = 1'b0;
        len_a_v = LW'(6);
        len_b_v = LW'(6);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        repeat (20) @(negedge clk);
        check("abort.busy_before", o_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort.score", o_score, 0);
        check("abort.busy", o_busy, 0);
        check("abort.done", o_done, 0);
        check("abort.err", o_err, 0);
        check("abort.addr_a", o_addr_a, 0);
        check("abort.addr_b", o_addr_b, 0);
        last_a = '{0, 0};
        last_b = '{0, 0};
        dones  = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_done !== 1'b0) dones++;
        end
        rst_n = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (o_done !== 1'b0) dones++;
        end
        check("abort.no_done", dones, 0);
        $display("[TB] abort: reset asserted mid-run, done pulses seen=%0d", dones);

        run_case("after_reset", 0, 4, 3, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
